// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one synchronous SRAM fetch per cycle,
// buffers the returned word across decode stalls and redirects after the delay slot.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic        if_adel_out,
    input  logic        id_br_valid_in,
    input  logic        id_brcal_res_in,
    input  logic [31:0] id_bjpc_res_in,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        start_q, start_d;
    logic        ibuf_valid_q, ibuf_valid_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_target_q, br_target_d;

    logic        fs_allowin;
    logic        issue;
    logic        br_taken;
    logic        to_id;
    logic [31:0] nextpc;

    assign fs_allowin = !fs_valid_q || id_allowin_in;
    assign issue      = start_q && fs_allowin;
    assign br_taken   = id_br_valid_in && id_brcal_res_in;
    assign to_id      = fs_valid_q && id_allowin_in;

    always_comb begin
        if (br_taken) begin
            nextpc = id_bjpc_res_in;
        end else if (br_pend_q) begin
            nextpc = br_target_q;
        end else begin
            nextpc = fs_pc_q + 32'd4;
        end
    end

    always_comb begin
        fs_valid_d   = fs_valid_q;
        fs_pc_d      = fs_pc_q;
        start_d      = 1'b1;
        ibuf_valid_d = ibuf_valid_q;
        ibuf_d       = ibuf_q;
        br_pend_d    = br_pend_q;
        br_target_d  = br_target_q;

        // With fs_allowin set, valid follows start: issue when started, else drain.
        if (fs_allowin) begin
            fs_valid_d = start_q;
        end
        if (issue) begin
            fs_pc_d   = nextpc;
            br_pend_d = 1'b0;
        end else if (br_taken) begin
            br_pend_d   = 1'b1;
            br_target_d = id_bjpc_res_in;
        end

        // SRAM data is only good one cycle after the request, so hold it while stalled.
        if (to_id) begin
            ibuf_valid_d = 1'b0;
        end else if (fs_valid_q && !ibuf_valid_q) begin
            ibuf_valid_d = 1'b1;
            ibuf_d       = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_valid_q   <= 1'b0;
            fs_pc_q      <= RESET_PC - 32'd4;
            start_q      <= 1'b0;
            ibuf_valid_q <= 1'b0;
            ibuf_q       <= '0;
            br_pend_q    <= 1'b0;
            br_target_q  <= '0;
        end else begin
            fs_valid_q   <= fs_valid_d;
            fs_pc_q      <= fs_pc_d;
            start_q      <= start_d;
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_q       <= ibuf_d;
            br_pend_q    <= br_pend_d;
            br_target_q  <= br_target_d;
        end
    end

    assign if_valid_out    = fs_valid_q;
    assign if_PC_out       = fs_pc_q;
    assign if_NPC_out      = fs_pc_q + 32'd4;
    assign if_NNPC_out     = fs_pc_q + 32'd8;
    assign if_Instruct_out = ibuf_valid_q ? ibuf_q : inst_sram_rdata;
    assign if_adel_out     = fs_valid_q && (fs_pc_q[1:0] != 2'b00);
    assign inst_sram_en    = issue;
    assign inst_sram_addr  = nextpc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage with a one-cycle-latency SRAM model
// that returns junk on cycles without a request.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_allowin_in;
    logic        if_valid_out;
    logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out;
    logic        if_adel_out;
    logic        id_br_valid_in, id_brcal_res_in;
    logic [31:0] id_bjpc_res_in;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr, inst_sram_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] junk_cnt = '0;

    if_fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .id_allowin_in(id_allowin_in),
        .if_valid_out(if_valid_out), .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out),
        .if_NNPC_out(if_NNPC_out), .if_Instruct_out(if_Instruct_out), .if_adel_out(if_adel_out),
        .id_br_valid_in(id_br_valid_in), .id_brcal_res_in(id_brcal_res_in),
        .id_bjpc_res_in(id_bjpc_res_in), .inst_sram_en(inst_sram_en),
        .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    always @(posedge clk) begin
        junk_cnt <= junk_cnt + 16'd1;
        inst_sram_rdata <= inst_sram_en ? word_of(inst_sram_addr) : {16'hDEAD, junk_cnt};
    end

    typedef struct {
        logic        a;
        logic        bv;
        logic        bc;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        een;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[25];

    function automatic vec_t mk(input logic a, input logic bv, input logic bc, input logic [31:0] tgt,
                                input logic ev, input logic [31:0] epc, input logic een,
                                input logic [31:0] eaddr);
        vec_t v;
        v.a = a; v.bv = bv; v.bc = bc; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.een = een; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string nm, input logic ev, input logic [31:0] epc,
                         input logic een, input logic [31:0] eaddr);
        logic bad;
        logic eadel;
        bad   = 1'b0;
        eadel = ev && (epc[1:0] != 2'b00);
        n_vec++;
        if (if_valid_out !== ev) begin
            $display("FAIL %s valid got %b want %b", nm, if_valid_out, ev); bad = 1'b1;
        end
        if (if_PC_out !== epc) begin
            $display("FAIL %s pc got %h want %h", nm, if_PC_out, epc); bad = 1'b1;
        end
        if (if_NPC_out !== epc + 32'd4 || if_NNPC_out !== epc + 32'd8) begin
            $display("FAIL %s npc/nnpc got %h/%h want %h/%h", nm, if_NPC_out, if_NNPC_out,
                     epc + 32'd4, epc + 32'd8); bad = 1'b1;
        end
        if (inst_sram_en !== een) begin
            $display("FAIL %s sram_en got %b want %b", nm, inst_sram_en, een); bad = 1'b1;
        end
        if (inst_sram_addr !== eaddr) begin
            $display("FAIL %s sram_addr got %h want %h", nm, inst_sram_addr, eaddr); bad = 1'b1;
        end
        if (if_adel_out !== eadel) begin
            $display("FAIL %s adel got %b want %b", nm, if_adel_out, eadel); bad = 1'b1;
        end
        if (ev && if_Instruct_out !== word_of(epc)) begin
            $display("FAIL %s instr got %h want %h", nm, if_Instruct_out, word_of(epc)); bad = 1'b1;
        end
        if (bad) n_err++;
    endtask

    initial begin
        //            a  bv bc tgt           ev pc            en addr
        vt[0]  = mk(1, 0, 0, 32'h0,        0, 32'hBFBF_FFFC, 0, 32'hBFC0_0000);
        vt[1]  = mk(1, 0, 0, 32'h0,        0, 32'hBFBF_FFFC, 1, 32'hBFC0_0000);
        vt[2]  = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0000, 1, 32'hBFC0_0004);
        vt[3]  = mk(0, 0, 0, 32'h0,        1, 32'hBFC0_0004, 0, 32'hBFC0_0008);
        vt[4]  = mk(0, 0, 0, 32'h0,        1, 32'hBFC0_0004, 0, 32'hBFC0_0008);
        vt[5]  = mk(0, 0, 0, 32'h0,        1, 32'hBFC0_0004, 0, 32'hBFC0_0008);
        vt[6]  = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0004, 1, 32'hBFC0_0008);
        vt[7]  = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0008, 1, 32'hBFC0_000C);
        vt[8]  = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_000C, 1, 32'hBFC0_0010);
        vt[9]  = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0010, 1, 32'hBFC0_0014);
        vt[10] = mk(1, 1, 1, 32'hBFC0_0100, 1, 32'hBFC0_0014, 1, 32'hBFC0_0100);
        vt[11] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0100, 1, 32'hBFC0_0104);
        vt[12] = mk(1, 1, 0, 32'hBFC0_0200, 1, 32'hBFC0_0104, 1, 32'hBFC0_0108);
        vt[13] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0108, 1, 32'hBFC0_010C);
        vt[14] = mk(0, 1, 1, 32'hBFC0_0300, 1, 32'hBFC0_010C, 0, 32'hBFC0_0300);
        vt[15] = mk(0, 0, 0, 32'h0,        1, 32'hBFC0_010C, 0, 32'hBFC0_0300);
        vt[16] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_010C, 1, 32'hBFC0_0300);
        vt[17] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0300, 1, 32'hBFC0_0304);
        vt[18] = mk(1, 1, 1, 32'hBFC0_0302, 1, 32'hBFC0_0304, 1, 32'hBFC0_0302);
        vt[19] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0302, 1, 32'hBFC0_0306);
        vt[20] = mk(1, 0, 0, 32'h0,        1, 32'hBFC0_0306, 1, 32'hBFC0_030A);
        vt[21] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hBFC0_030A, 1, 32'hFFFF_FFFC);
        vt[22] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0000_0000);
        vt[23] = mk(1, 0, 0, 32'h0,        1, 32'h0000_0000, 1, 32'h0000_0004);
        vt[24] = mk(0, 1, 1, 32'h0000_0500, 1, 32'h0000_0004, 0, 32'h0000_0500);

        rst = 1'b1;
        id_allowin_in = 1'b1;
        id_br_valid_in = 1'b0;
        id_brcal_res_in = 1'b0;
        id_bjpc_res_in = '0;
        repeat (2) @(negedge clk);
        #1 check("reset", 1'b0, 32'hBFBF_FFFC, 1'b0, 32'hBFC0_0000);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            id_allowin_in   = vt[i].a;
            id_br_valid_in  = vt[i].bv;
            id_brcal_res_in = vt[i].bc;
            id_bjpc_res_in  = vt[i].tgt;
            #1 check($sformatf("v%0d", i), vt[i].ev, vt[i].epc, vt[i].een, vt[i].eaddr);
        end

        // Stalled with a redirect pending (armed by v24); async reset must wipe it.
        @(posedge clk);
        #1;
        id_br_valid_in  = 1'b0;
        id_brcal_res_in = 1'b0;
        id_allowin_in   = 1'b1;
        rst = 1'b1;
        #1 check("rst_async", 1'b0, 32'hBFBF_FFFC, 1'b0, 32'hBFC0_0000);
        @(negedge clk);
        #1 check("rst_held", 1'b0, 32'hBFBF_FFFC, 1'b0, 32'hBFC0_0000);
        @(negedge clk);
        rst = 1'b0;
        #1 check("restart0", 1'b0, 32'hBFBF_FFFC, 1'b0, 32'hBFC0_0000);
        @(negedge clk);
        #1 check("restart1", 1'b0, 32'hBFBF_FFFC, 1'b1, 32'hBFC0_0000);
        @(negedge clk);
        #1 check("restart2", 1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
